// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU control: ALU operation codes,
// ALUOp encodings, R-type / multiply-divide funct values and the
// multiply/divide sequencer state type.
package alu_pkg;

  // ALU operation codes driven to the ALU
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  // ALUOp encodings from main control
  localparam logic [1:0] ALUOP_MEM   = 2'b00;  // load/store address add
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;  // branch compare subtract
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // decode the funct field
  localparam logic [1:0] ALUOP_IMM   = 2'b11;  // immediate add

  // R-type ALU funct values
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  // Multiply/divide funct values
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

  // Multiply/divide class: funct 0100xx or 0110xx
  function automatic logic is_md_funct(input logic [5:0] f);
    return (f[5:4] == 2'b01) && (f[2] == 1'b0);
  endfunction

endpackage

// File: rtl/alu_control_md_md_seq.sv
// Multiply/divide sequencer with the HI/LO registers. Works on operand
// magnitudes and applies sign corrections in a final FIX cycle.
// Build option: FAST_MUL_EN replaces the iterative multiply with a
// registered full-width multiply (MUL holds one cycle, then FIX).
module md_seq
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_md_hit,
  input  logic              i_flush,
  input  logic [5:0]        i_funct,
  input  logic [DATA_W-1:0] i_rs,
  input  logic [DATA_W-1:0] i_rt,
  output logic              o_busy,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  md_state_e         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_acc;     // product high half / partial remainder
  logic [DATA_W-1:0] r_qlo;     // multiplier then product low half / quotient
  logic [DATA_W-1:0] r_opb;     // multiplicand / divisor magnitude
  logic              r_neg_lo;  // product sign or quotient sign
  logic              r_neg_hi;  // remainder sign (follows dividend)
  logic              r_dz;      // divisor was zero
  logic              r_is_div;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  logic              w_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [DATA_W-1:0] w_a_mag;
  logic [DATA_W-1:0] w_b_mag;
  logic              w_last;

  assign w_signed = (i_funct == F_MULT) || (i_funct == F_DIV);
  assign w_a_neg  = w_signed & i_rs[DATA_W-1];
  assign w_b_neg  = w_signed & i_rt[DATA_W-1];
  assign w_a_mag  = w_a_neg ? -i_rs : i_rs;
  assign w_b_mag  = w_b_neg ? -i_rt : i_rt;
  assign w_last   = (r_cnt == CNT_W'(DATA_W - 1));

`ifdef FAST_MUL_EN
  logic [2*DATA_W-1:0] w_fast_prod;
  assign w_fast_prod = {{DATA_W{1'b0}}, r_qlo} * {{DATA_W{1'b0}}, r_opb};
`else
  // Shift-add step: add multiplicand when the current multiplier bit is set,
  // then shift the {acc, qlo} pair right by one.
  logic [DATA_W:0] w_mul_sum;
  assign w_mul_sum = {1'b0, r_acc} + (r_qlo[0] ? {1'b0, r_opb} : {(DATA_W+1){1'b0}});
`endif

  // Restoring divide step: shift in the next dividend bit, subtract if it fits.
  // When the subtraction fits, the true result is below the divisor, so the
  // truncated W-bit difference is exact.
  logic [DATA_W:0]   w_div_tmp;
  logic              w_div_ge;
  logic [DATA_W-1:0] w_div_sub;
  assign w_div_tmp = {r_acc, r_qlo[DATA_W-1]};
  assign w_div_ge  = (w_div_tmp >= {1'b0, r_opb});
  assign w_div_sub = w_div_tmp[DATA_W-1:0] - r_opb;

  // Sign corrections applied in FIX
  logic [2*DATA_W-1:0] w_prod;
  logic [2*DATA_W-1:0] w_prod_fix;
  logic [DATA_W-1:0]   w_quo_fix;
  logic [DATA_W-1:0]   w_rem_fix;
  assign w_prod     = {r_acc, r_qlo};
  assign w_prod_fix = r_neg_lo ? -w_prod : w_prod;
  assign w_quo_fix  = r_dz ? {DATA_W{1'b1}} : (r_neg_lo ? -r_qlo : r_qlo);
  assign w_rem_fix  = r_neg_hi ? -r_acc : r_acc;

  // Sequencer FSM, datapath and HI/LO update
  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values, matching real flop behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: HI/LO are architecturally visible, so they are reset along with
      // the control state rather than left as unreset storage.
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_qlo    <= '0;
      r_opb    <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dz     <= 1'b0;
      r_is_div <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_md_hit && !i_flush) begin
            case (i_funct)
              F_MULT, F_MULTU: begin
                r_acc    <= '0;
                r_qlo    <= w_a_mag;
                r_opb    <= w_b_mag;
                r_neg_lo <= w_a_neg ^ w_b_neg;
                r_neg_hi <= 1'b0;
                r_dz     <= 1'b0;
                r_is_div <= 1'b0;
                r_cnt    <= '0;
                r_state  <= ST_MUL;
              end
              F_DIV, F_DIVU: begin
                r_acc    <= '0;
                r_qlo    <= w_a_mag;
                r_opb    <= w_b_mag;
                r_neg_lo <= w_a_neg ^ w_b_neg;
                r_neg_hi <= w_a_neg;
                r_dz     <= (w_b_mag == '0);
                r_is_div <= 1'b1;
                r_cnt    <= '0;
                r_state  <= ST_DIV;
              end
              F_MTHI:  r_hi <= i_rs;
              F_MTLO:  r_lo <= i_rs;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (i_flush) begin
            r_state <= ST_IDLE;
          end else begin
`ifdef FAST_MUL_EN
            {r_acc, r_qlo} <= w_fast_prod;
            r_state        <= ST_FIX;
`else
            r_acc <= w_mul_sum[DATA_W:1];
            r_qlo <= {w_mul_sum[0], r_qlo[DATA_W-1:1]};
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_state <= ST_FIX;
`endif
          end
        end
        ST_DIV: begin
          if (i_flush) begin
            r_state <= ST_IDLE;
          end else begin
            r_acc <= w_div_ge ? w_div_sub : w_div_tmp[DATA_W-1:0];
            r_qlo <= {r_qlo[DATA_W-2:0], w_div_ge};
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (!i_flush) begin
            if (r_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              {r_hi, r_lo} <= w_prod_fix;
            end
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = (r_state != ST_IDLE);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: rtl/alu_control_md.sv
// EX-stage ALU control: combinational ALUOp/funct decode, pipeline stall
// for instructions that depend on a running multiply/divide, and MFHI/MFLO
// read-out. The sequencer itself lives in md_seq.
// Build option: FAST_MUL_EN (see md_seq) selects a 2-cycle multiply.
module alu_control_md
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              flush,
  output logic [3:0]        alu_operation,
  output logic              illegal,
  output logic              stall,
  output logic              md_busy,
  output logic [DATA_W-1:0] mf_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic              w_md_hit;
  logic              w_busy;
  logic [DATA_W-1:0] w_hi;
  logic [DATA_W-1:0] w_lo;

  assign w_md_hit = issue && (alu_op == ALUOP_RTYPE) && is_md_funct(funct);

  md_seq #(.DATA_W(DATA_W)) u_md_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_md_hit (w_md_hit),
    .i_flush  (flush),
    .i_funct  (funct),
    .i_rs     (rs_val),
    .i_rt     (rt_val),
    .o_busy   (w_busy),
    .o_hi     (w_hi),
    .o_lo     (w_lo)
  );

  // ALU operation decode from ALUOp and funct
  // NOTE: outputs get defaults before the case so no path leaves them
  // unassigned, which would otherwise infer latches.
  always_comb begin
    alu_operation = ALU_ADD;
    illegal       = 1'b0;
    case (alu_op)
      ALUOP_BEQ: alu_operation = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: alu_operation = ALU_ADD;
          F_SUB, F_SUBU: alu_operation = ALU_SUB;
          F_AND:         alu_operation = ALU_AND;
          F_OR:          alu_operation = ALU_OR;
          F_XOR:         alu_operation = ALU_XOR;
          F_NOR:         alu_operation = ALU_NOR;
          F_SLT:         alu_operation = ALU_SLT;
          F_SLTU:        alu_operation = ALU_SLTU;
          default:       illegal = !is_md_funct(funct);
        endcase
      end
      default: ;
    endcase
  end

  // HI/LO read-out for MFHI/MFLO, zero otherwise
  always_comb begin
    mf_data = '0;
    if (w_md_hit) begin
      if (funct == F_MFHI)      mf_data = w_hi;
      else if (funct == F_MFLO) mf_data = w_lo;
    end
  end

  // Any MD-class instruction waits while the sequencer is busy
  assign stall   = w_md_hit & w_busy & ~flush;
  assign md_busy = w_busy;
  assign hi      = w_hi;
  assign lo      = w_lo;

endmodule

// File: tb/tb_alu_control_md.sv
// Directed self-checking bench for alu_control_md (DATA_W = 32).
module tb_alu_control_md;

  localparam int DATA_W = 32;
`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = DATA_W + 1;
`endif
  localparam int DIV_LAT = DATA_W + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              issue;
  logic [1:0]        alu_op;
  logic [5:0]        funct;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              flush;
  logic [3:0]        alu_operation;
  logic              illegal;
  logic              stall;
  logic              md_busy;
  logic [DATA_W-1:0] mf_data;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  int n_checks = 0;
  int n_pass   = 0;

  alu_control_md #(.DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue         (issue),
    .alu_op        (alu_op),
    .funct         (funct),
    .rs_val        (rs_val),
    .rt_val        (rt_val),
    .flush         (flush),
    .alu_operation (alu_operation),
    .illegal       (illegal),
    .stall         (stall),
    .md_busy       (md_busy),
    .mf_data       (mf_data),
    .hi            (hi),
    .lo            (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {illegal, alu_operation} from the decode table
  function automatic logic [4:0] exp_decode(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b01) return 5'b0_0110;
    if (op != 2'b10) return 5'b0_0010;
    case (fn)
      6'b100000, 6'b100001: return 5'b0_0010;
      6'b100010, 6'b100011: return 5'b0_0110;
      6'b100100: return 5'b0_0000;
      6'b100101: return 5'b0_0001;
      6'b100110: return 5'b0_0011;
      6'b100111: return 5'b0_1100;
      6'b101010: return 5'b0_0111;
      6'b101011: return 5'b0_1000;
      6'b010000, 6'b010001, 6'b010010, 6'b010011,
      6'b011000, 6'b011001, 6'b011010, 6'b011011: return 5'b0_0010;
      default: return 5'b1_0010;
    endcase
  endfunction

  // Issue one MD instruction for a single cycle
  task automatic issue_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    issue = 1'b1; alu_op = 2'b10; funct = fn; rs_val = a; rt_val = b;
    tick();
    issue = 1'b0; funct = 6'b000000; rs_val = '0; rt_val = '0;
  endtask

  // Run MULT/DIV to completion and check busy timing and HI/LO
  task automatic run_md(input string tag, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue_md(fn, a, b);
    repeat (lat - 1) tick();
    check({tag, "_busy_before"}, md_busy, 1);
    tick();
    check({tag, "_busy_after"}, md_busy, 0);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; issue = 1'b0; alu_op = 2'b00; funct = 6'b0;
    rs_val = '0; rt_val = '0; flush = 1'b0;
    #2;
    check("rst_stall",   stall,   0);
    check("rst_busy",    md_busy, 0);
    check("rst_mf_data", mf_data, 0);
    check("rst_hi",      hi,      0);
    check("rst_lo",      lo,      0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Decode sweep over every ALUOp/funct pair (issue low)
    for (int op = 0; op < 4; op++) begin
      for (int fn = 0; fn < 64; fn++) begin
        alu_op = 2'(op); funct = 6'(fn);
        #1;
        check($sformatf("decode_op%0d_fn%0d", op, fn), {illegal, alu_operation},
              exp_decode(2'(op), 6'(fn)));
      end
    end
    alu_op = 2'b10; funct = 6'b000111;
    #1;
    check("illegal_000111", illegal, 1);
    check("illegal_000111_op", alu_operation, 4'b0010);
    alu_op = 2'b00; funct = 6'b0;
    tick();

    // Multiply
    run_md("mult_neg",  6'b011000, 32'hFFFF_FFFE, 32'h0000_0003, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_md("multu",     6'b011001, 32'hFFFF_FFFE, 32'h0000_0003, MUL_LAT, 32'h0000_0002, 32'hFFFF_FFFA);
    run_md("multu_ffff", 6'b011001, 32'h0000_FFFF, 32'h0000_FFFF, MUL_LAT, 32'h0000_0000, 32'hFFFE_0001);

    // Divide, including the boundary cases
    run_md("div_neg",   6'b011010, 32'hFFFF_FFF9, 32'h0000_0002, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu",      6'b011011, 32'hFFFF_FFF9, 32'h0000_0002, DIV_LAT, 32'h0000_0001, 32'h7FFF_FFFC);
    run_md("div_zero",  6'b011010, 32'h1234_5678, 32'h0000_0000, DIV_LAT, 32'h1234_5678, 32'hFFFF_FFFF);
    run_md("div_zero_neg", 6'b011010, 32'h8000_0005, 32'h0000_0000, DIV_LAT, 32'h8000_0005, 32'hFFFF_FFFF);
    run_md("div_min",   6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'h0000_0000, 32'h8000_0000);

    // MTHI / MTLO / MFHI / MFLO
    issue_md(6'b010001, 32'hAAAA_5555, 32'h0);
    issue_md(6'b010011, 32'h1234_ABCD, 32'h0);
    check("mthi", hi, 32'hAAAA_5555);
    check("mtlo", lo, 32'h1234_ABCD);
    issue = 1'b1; alu_op = 2'b10; funct = 6'b010000;
    #1 check("mfhi", mf_data, 32'hAAAA_5555);
    funct = 6'b010010;
    #1 check("mflo", mf_data, 32'h1234_ABCD);
    funct = 6'b100000;
    #1 check("mf_data_add", mf_data, 0);
    issue = 1'b0;
    tick();

    // Flush while in IDLE: neither MTHI nor MULT takes effect
    flush = 1'b1;
    issue_md(6'b010001, 32'hDEAD_BEEF, 32'h0);
    check("flush_idle_mthi", hi, 32'hAAAA_5555);
    issue_md(6'b011000, 32'h5, 32'h7);
    check("flush_idle_busy", md_busy, 0);
    flush = 1'b0;

    // Flush ten cycles into a DIV: back to IDLE, HI/LO untouched
    issue_md(6'b011010, 32'd100, 32'd7);
    repeat (9) tick();
    check("div_busy_pre_flush", md_busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_div_busy", md_busy, 0);
    repeat (40) tick();
    check("flush_div_hi", hi, 32'hAAAA_5555);
    check("flush_div_lo", lo, 32'h1234_ABCD);

    // Dependent MFLO five cycles after MULT stalls until the result lands
    issue_md(6'b011000, 32'd5, 32'd7);
    issue = 1'b1; alu_op = 2'b10; funct = 6'b100000;
    #1;
    check("add_no_stall", stall, 0);
    check("add_op", alu_operation, 4'b0010);
    tick();
    issue = 1'b0;
    repeat (3) tick();
    issue = 1'b1; alu_op = 2'b10; funct = 6'b010010;
    #1;
    check("mflo_stall_start", stall, (MUL_LAT > 4) ? 1 : 0);
    n = 0;
    while (stall && n < 100) begin
      tick();
      n++;
    end
    check("mflo_stall_cycles", n, (MUL_LAT > 4) ? MUL_LAT - 4 : 0);
    check("mflo_busy_done", md_busy, 0);
    check("mflo_data", mf_data, 32'd35);
    issue = 1'b0;
    tick();

    // Asynchronous reset in the middle of a MULT
    issue_md(6'b011001, 32'hFFFF_FFFE, 32'h0000_0003);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_hi",   hi,      0);
    check("rst_mid_lo",   lo,      0);
    check("rst_mid_busy", md_busy, 0);
    check("rst_mid_stall", stall,  0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", md_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
